// File: rtl/spectrum_seq_ctrl.sv
// Frame scheduler for the spectrum chain: capture/FFT, two-tone analysis, analyzer release,
// optional auto-repeat. Also arbitrates the magnitude-RAM read port between analyzer and display.
module spectrum_seq_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int TIMEOUT  = 1_000_000,
  parameter int KEY_W    = 2,
  parameter int HOLD_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              auto_mode,
  output logic              fft_start,
  input  logic              cap_done,
  output logic              ana_en,
  output logic              ana_key,
  input  logic              ana_valid,
  input  logic [7:0]        ana_freqA,
  input  logic [7:0]        ana_freqB,
  input  logic              ana_sinA,
  input  logic              ana_sinB,
  input  logic [ADDR_W-1:0] ana_addr,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_gnt,
  output logic [7:0]        res_freqA,
  output logic [7:0]        res_freqB,
  output logic              res_sinA,
  output logic              res_sinB,
  output logic              result_valid,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       frame_cnt
);

  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam int SEQ_MAX = (HOLD_CYC > KEY_W) ? HOLD_CYC : KEY_W;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [SEQ_W-1:0] KEY_LAST  = SEQ_W'(KEY_W - 1);
  localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, ANALYZE, RELEASE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [SEQ_W-1:0]  seq_cnt;
  logic              vld_d;
  logic              done_ok;
  logic              ok_nxt, fft_nxt, latch, set_err, clr_err, key_low;
  logic              tmo_hit, vld_rise, key_done;

  assign ram_addr  = (state == ANALYZE) ? ana_addr : disp_addr;
  assign disp_gnt  = (state != ANALYZE);
  assign disp_data = ram_data;

  always_comb begin
    state_nxt = state;
    fft_nxt   = 1'b0;
    latch     = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    ok_nxt    = done_ok;
    tmo_hit   = (tmo_cnt == TMO_LAST);
    vld_rise  = ana_valid & ~vld_d;
    key_done  = (seq_cnt >= KEY_LAST);
    case (state)
      IDLE: if (start) begin
        fft_nxt   = 1'b1;
        clr_err   = 1'b1;
        ok_nxt    = 1'b0;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (stop) begin
          ok_nxt    = 1'b0;
          state_nxt = RELEASE;
        end else if (cap_done) begin
          state_nxt = ANALYZE;
        end else if (tmo_hit) begin
          set_err   = 1'b1;
          ok_nxt    = 1'b0;
          state_nxt = RELEASE;
        end
      end
      // stop beats a result, and a result beats a timeout
      ANALYZE: begin
        if (stop) begin
          ok_nxt    = 1'b0;
          state_nxt = RELEASE;
        end else if (vld_rise) begin
          latch     = 1'b1;
          ok_nxt    = 1'b1;
          state_nxt = RELEASE;
        end else if (tmo_hit) begin
          set_err   = 1'b1;
          ok_nxt    = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: if (key_done && !ana_valid) begin
        state_nxt = (done_ok && auto_mode) ? HOLD : IDLE;
      end
      HOLD: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (seq_cnt == HOLD_LAST) begin
          if (auto_mode) begin
            fft_nxt   = 1'b1;
            ok_nxt    = 1'b0;
            state_nxt = CAPTURE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // key is low from the RELEASE entry edge until KEY_W cycles have elapsed
    key_low = (state_nxt == RELEASE) && !((state == RELEASE) && key_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      seq_cnt      <= '0;
      vld_d        <= 1'b0;
      done_ok      <= 1'b0;
      fft_start    <= 1'b0;
      ana_en       <= 1'b0;
      ana_key      <= 1'b1;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      frame_cnt    <= '0;
      res_freqA    <= '0;
      res_freqB    <= '0;
      res_sinA     <= 1'b0;
      res_sinB     <= 1'b0;
    end else begin
      state        <= state_nxt;
      vld_d        <= ana_valid;
      done_ok      <= ok_nxt;
      fft_start    <= fft_nxt;
      ana_en       <= (state_nxt == ANALYZE);
      ana_key      <= ~key_low;
      result_valid <= latch;
      busy         <= (state_nxt != IDLE);
      if (state_nxt != state) begin
        tmo_cnt <= '0;
        seq_cnt <= '0;
      end else begin
        if (((state == CAPTURE) || (state == ANALYZE)) && (tmo_cnt != '1))
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (((state == RELEASE) || (state == HOLD)) && (seq_cnt != '1))
          seq_cnt <= seq_cnt + SEQ_W'(1);
      end
      if (set_err)
        err_timeout <= 1'b1;
      else if (clr_err)
        err_timeout <= 1'b0;
      if (latch) begin
        res_freqA <= ana_freqA;
        res_freqB <= ana_freqB;
        res_sinA  <= ana_sinA;
        res_sinB  <= ana_sinB;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_seq_ctrl.sv
// Directed scoreboard bench for spectrum_seq_ctrl: single shot, auto mode, arbitration,
// timeout, race cases and mid-frame reset.
module tb_spectrum_seq_ctrl;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int TIMEOUT  = 64;
  localparam int KEY_W    = 2;
  localparam int HOLD_CYC = 16;
  localparam int CAP_DLY  = 20;
  localparam int ANA_DLY  = 30;
  localparam int VLD_HOLD = 3;
  // fft_start -> ANALYZE entry (CAP_DLY+1) -> RELEASE entry (ANA_DLY+1)
  // -> HOLD entry (VLD_HOLD+1) -> next fft_start (HOLD_CYC) = 21+31+4+16
  localparam int FRAME_GAP = 72;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, stop = 1'b0, auto_mode = 1'b0;
  logic              cap_done = 1'b0, ana_valid = 1'b0;
  logic [7:0]        ana_freqA = '0, ana_freqB = '0;
  logic              ana_sinA = 1'b0, ana_sinB = 1'b0;
  logic [ADDR_W-1:0] ana_addr = 8'hAA, disp_addr = 8'h55;
  logic [DATA_W-1:0] ram_data = 16'h1234;
  logic              fft_start, ana_en, ana_key, disp_gnt, result_valid, busy, err_timeout;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] disp_data;
  logic [7:0]        res_freqA, res_freqB;
  logic              res_sinA, res_sinB;
  logic [15:0]       frame_cnt;

  typedef struct packed {
    logic [7:0]  fa;
    logic [7:0]  fb;
    logic        sa;
    logic        sb;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  int   fft_cnt = 0, rv_cnt = 0, en_rise = 0, key_low_cyc = 0;
  logic en_d = 1'b0;
  int   ts[1:3];
  int   b_fft, b_rv, b_key, b_en;

  spectrum_seq_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .KEY_W(KEY_W), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .auto_mode(auto_mode),
    .fft_start(fft_start), .cap_done(cap_done), .ana_en(ana_en), .ana_key(ana_key),
    .ana_valid(ana_valid), .ana_freqA(ana_freqA), .ana_freqB(ana_freqB),
    .ana_sinA(ana_sinA), .ana_sinB(ana_sinB), .ana_addr(ana_addr), .disp_addr(disp_addr),
    .ram_addr(ram_addr), .ram_data(ram_data), .disp_data(disp_data), .disp_gnt(disp_gnt),
    .res_freqA(res_freqA), .res_freqB(res_freqB), .res_sinA(res_sinA), .res_sinB(res_sinB),
    .result_valid(result_valid), .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: event counters plus result scoreboard
  always begin
    @(posedge clk);
    #2;
    if (fft_start === 1'b1) fft_cnt++;
    if (ana_en === 1'b1 && en_d == 1'b0) en_rise++;
    en_d = (ana_en === 1'b1);
    if (ana_key === 1'b0) key_low_cyc++;
    if (result_valid === 1'b1) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        check("result_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {res_freqA, res_freqB, res_sinA, res_sinB, frame_cnt}, mon_e);
        check("disp_data", disp_data, ram_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n;
    n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    check(nm, busy, 0);
  endtask

  task automatic wait_fft(input int lim, input string nm);
    int n;
    n = 0;
    while (!fft_start && n < lim) begin
      tick();
      n++;
    end
    check(nm, fft_start, 1);
  endtask

  // Entered right after the fft_start edge; leaves just before RELEASE can exit.
  task automatic run_frame(input logic [7:0] fa, input logic [7:0] fb,
                           input logic sa, input logic sb, input logic [15:0] fc);
    exp_t e;
    repeat (CAP_DLY) tick();
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    check("anz_en", ana_en, 1);
    check("anz_addr", ram_addr, 8'hAA);
    check("anz_gnt", disp_gnt, 0);
    ana_freqA = fa;
    ana_freqB = fb;
    ana_sinA  = sa;
    ana_sinB  = sb;
    repeat (ANA_DLY) tick();
    e = exp_t'({fa, fb, sa, sb, fc});
    exp_q.push_back(e);
    ana_valid = 1'b1;
    tick();
    check("rel_en", ana_en, 0);
    check("rel_key", ana_key, 0);
    check("rel_addr", ram_addr, 8'h55);
    check("rel_gnt", disp_gnt, 1);
    repeat (VLD_HOLD) tick();
    ana_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_key", ana_key, 1);
    check("rst_en", ana_en, 0);
    check("rst_fft", fft_start, 0);
    check("rst_rv", result_valid, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_err", err_timeout, 0);
    check("rst_res", {res_freqA, res_freqB, res_sinA, res_sinB}, 0);
    check("idle_addr", ram_addr, 8'h55);
    check("idle_gnt", disp_gnt, 1);

    // Single shot
    b_fft = fft_cnt; b_rv = rv_cnt; b_key = key_low_cyc;
    pulse_start();
    check("ss_fft", fft_start, 1);
    check("ss_busy", busy, 1);
    check("cap_addr", ram_addr, 8'h55);
    check("cap_gnt", disp_gnt, 1);
    run_frame(8'd10, 8'd30, 1'b1, 1'b0, 16'd1);
    wait_idle(20, "ss_idle");
    check("ss_cnt", frame_cnt, 1);
    check("ss_key_after", ana_key, 1);
    check("ss_fft_pulses", fft_cnt - b_fft, 1);
    check("ss_rv_pulses", rv_cnt - b_rv, 1);
    check("ss_key_width", key_low_cyc - b_key, KEY_W);

    // Auto mode, three frames then stop in HOLD
    do_reset();
    auto_mode = 1'b1;
    b_fft = fft_cnt; b_en = en_rise;
    for (int f = 1; f <= 3; f++) begin
      if (f == 1) pulse_start();
      else wait_fft(200, "auto_fft");
      ts[f] = cyc;
      if (f > 1) check("auto_gap", ts[f] - ts[f-1], FRAME_GAP);
      run_frame(8'(f * 3), 8'(f * 5), f[0], ~f[0], 16'(f));
      tick();
      check("hold_busy", busy, 1);
      check("hold_addr", ram_addr, 8'h55);
      check("hold_gnt", disp_gnt, 1);
    end
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("auto_stop_idle", busy, 0);
    check("auto_cnt", frame_cnt, 3);
    check("auto_en_rises", en_rise - b_en, 3);
    auto_mode = 1'b0;
    repeat (40) tick();
    check("auto_fft_pulses", fft_cnt - b_fft, 3);

    // Timeout in CAPTURE; results from frame 3 (9,15,1,0) must survive
    pulse_start();
    repeat (TIMEOUT - 1) tick();
    check("tmo_pre_err", err_timeout, 0);
    check("tmo_pre_busy", busy, 1);
    tick();
    check("tmo_err", err_timeout, 1);
    check("tmo_key", ana_key, 0);
    wait_idle(10, "tmo_idle");
    check("tmo_sticky", err_timeout, 1);
    check("tmo_res", {res_freqA, res_freqB, res_sinA, res_sinB}, {8'd9, 8'd15, 1'b1, 1'b0});
    check("tmo_cnt", frame_cnt, 3);
    pulse_start();
    check("tmo_clear", err_timeout, 0);

    // Race: stop and ana_valid rise together
    repeat (2) tick();
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    ana_freqA = 8'd77; ana_freqB = 8'd88; ana_sinA = 1'b0; ana_sinB = 1'b0;
    repeat (5) tick();
    stop = 1'b1;
    ana_valid = 1'b1;
    tick();
    stop = 1'b0;
    check("race1_key", ana_key, 0);
    check("race1_rv", result_valid, 0);
    check("race1_cnt", frame_cnt, 3);
    repeat (3) tick();
    ana_valid = 1'b0;
    wait_idle(10, "race1_idle");
    check("race1_res", {res_freqA, res_freqB, res_sinA, res_sinB}, {8'd9, 8'd15, 1'b1, 1'b0});

    // Race: ana_valid rise on the timeout cycle in ANALYZE
    pulse_start();
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    ana_freqA = 8'd200; ana_freqB = 8'd4; ana_sinA = 1'b0; ana_sinB = 1'b1;
    repeat (TIMEOUT - 1) tick();
    check("race2_pre", ana_en, 1);
    exp_q.push_back(exp_t'({8'd200, 8'd4, 1'b0, 1'b1, 16'd4}));
    ana_valid = 1'b1;
    tick();
    check("race2_err", err_timeout, 0);
    check("race2_rv", result_valid, 1);
    repeat (3) tick();
    ana_valid = 1'b0;
    wait_idle(10, "race2_idle");

    // Reset in the middle of ANALYZE
    pulse_start();
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    check("mid_en", ana_en, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_en_off", ana_en, 0);
    check("mid_key", ana_key, 1);
    check("mid_cnt", frame_cnt, 0);
    check("mid_res", {res_freqA, res_freqB, res_sinA, res_sinB}, 0);
    check("mid_gnt", disp_gnt, 1);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spectrum_seq_ctrl.md
Name: spectrum_seq_ctrl

Overview:
- Frame-level scheduler for the spectrum-analysis chain: triggers one capture+FFT+magnitude-RAM-write frame, then runs the two-tone frequency/shape analyzer on the stored magnitudes, then releases the analyzer.
- Owns the magnitude-RAM read port and time-shares it between the analyzer and the display/readout logic.
- Latches the analyzer results, counts frames, and supervises each phase with a timeout.
- Supports single-shot and free-running (auto) operation.

Parameters:
- ADDR_W, 8, magnitude RAM address width.
- DATA_W, 16, magnitude RAM data width.
- TIMEOUT, 1_000_000, maximum clk cycles allowed in CAPTURE or ANALYZE.
- KEY_W, 2, width in cycles of the analyzer release pulse (ana_key low).
- HOLD_CYC, 1024, gap in cycles between frames in auto mode.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- start  in  1  1-cycle pulse; begins a frame when in IDLE.
- stop  in  1  1-cycle pulse; aborts the current frame, or ends auto mode.
- auto_mode  in  1  1 = restart a frame automatically after HOLD.
- fft_start  out  1  1-cycle pulse to the capture/FFT front end.
- cap_done  in  1  1-cycle pulse; magnitude RAM fully written.
- ana_en  out  1  analyzer enable; the analyzer acts on its rising edge.
- ana_key  out  1  analyzer release, idle high; a falling edge returns the analyzer to idle.
- ana_valid  in  1  analyzer result-valid level.
- ana_freqA, ana_freqB  in  8 each  analyzer bin indices.
- ana_sinA, ana_sinB  in  1 each  analyzer shape flags (1 = sine).
- ana_addr  in  ADDR_W  analyzer RAM read address.
- disp_addr  in  ADDR_W  display RAM read address.
- ram_addr  out  ADDR_W  muxed RAM read address.
- ram_data  in  DATA_W  RAM read data.
- disp_data  out  DATA_W  ram_data forwarded to the display.
- disp_gnt  out  1  1 = display owns the RAM port this cycle.
- res_freqA, res_freqB  out  8 each  latched results.
- res_sinA, res_sinB  out  1 each  latched results.
- result_valid  out  1  1-cycle pulse when new results are latched.
- busy  out  1  high in any state except IDLE.
- err_timeout  out  1  sticky timeout flag.
- frame_cnt  out  16  completed-frame counter, wraps at 0xFFFF to 0.

Behaviour:
- Reset values (rst high at a clk edge; applies mid-operation too): state=IDLE, all res_* = 0, frame_cnt = 0, err_timeout = 0, fft_start = 0, result_valid = 0, ana_en = 0, ana_key = 1, counters = 0.
- States: IDLE, CAPTURE, ANALYZE, RELEASE, HOLD. All outputs are registered except ram_addr, disp_data and disp_gnt.
- IDLE:
  - On start: fft_start=1 for one cycle, err_timeout cleared, go to CAPTURE.
  - start while not in IDLE is ignored.
- CAPTURE:
  - On cap_done: go to ANALYZE and set ana_en=1 on the same edge.
  - If the timeout counter reaches TIMEOUT-1: set err_timeout, go to RELEASE.
- ANALYZE:
  - ana_en is held at 1.
  - On an ana_valid rising edge (sampled with a 1-cycle delayed copy): latch the ana_* result inputs into res_*, pulse result_valid, increment frame_cnt, go to RELEASE.
  - On timeout: set err_timeout, go to RELEASE. If ana_valid rises in the same cycle, the result wins and err_timeout is not set.
- RELEASE:
  - ana_en=0.
  - ana_key=0 for exactly KEY_W cycles from entry, then returns to 1.
  - After the pulse, wait for ana_valid==0.
  - Exit: if the frame completed normally and auto_mode=1, go to HOLD; otherwise go to IDLE.
- HOLD:
  - Count HOLD_CYC cycles, then issue the fft_start pulse and go to CAPTURE.
  - auto_mode sampled low at the end of the count: go to IDLE instead.
- stop:
  - In CAPTURE or ANALYZE: go to RELEASE (abort; no result latched, frame_cnt unchanged).
  - In HOLD: go to IDLE.
  - In RELEASE or IDLE: ignored.
  - stop wins over cap_done, ana_valid and timeout in the same cycle.
- Timeout counter:
  - Cleared on every state change.
  - Counts only in CAPTURE and ANALYZE.
  - Saturates and does not wrap.
- RAM arbitration:
  - In ANALYZE, ram_addr = ana_addr and disp_gnt = 0.
  - In all other states, ram_addr = disp_addr and disp_gnt = 1.
  - This mux is combinational and adds zero latency, so the analyzer's address-to-data timing is preserved.
  - disp_data = ram_data at all times; the display discards it when disp_gnt = 0.
- res_* hold their values until the next successful frame; an aborted or timed-out frame leaves them unchanged.

Test Plan:
- Single shot: auto_mode=0, start; cap_done 100 cycles later; ana_valid rises 500 cycles later with freqA=10, freqB=30, sinA=1, sinB=0 -> fft_start single pulse; res_freqA=10, res_freqB=30, res_sinA=1, res_sinB=0; result_valid single pulse; frame_cnt=1; ana_key low exactly 2 cycles; return to IDLE, busy=0.
- Auto mode, HOLD_CYC=16: three frames -> fft_start pulses spaced exactly by the frame time plus 16 HOLD cycles plus RELEASE time; frame_cnt=3; ana_en low for at least 1 cycle between its high periods; then stop in HOLD -> IDLE.
- Arbitration: disp_addr=0x55, ana_addr=0xAA -> ram_addr=0xAA and disp_gnt=0 only while in ANALYZE; ram_addr=0x55 and disp_gnt=1 in every other state.
- Timeout, TIMEOUT=64: no cap_done -> err_timeout=1 after 64 cycles in CAPTURE; RELEASE pulse issued; IDLE; res_* unchanged. A following start clears err_timeout.
- Races: stop and ana_valid rise in the same cycle -> no result latched, frame_cnt unchanged. ana_valid rise and timeout in the same cycle -> result latched, err_timeout=0.
- Reset mid-ANALYZE: rst high for 1 cycle -> next cycle state=IDLE, ana_en=0, ana_key=1, frame_cnt=0, res_*=0.
